// File: rtl/risc16_pkg.sv
// Shared RISC16 definitions: default widths, data-memory FSM encoding, memory opcodes.
package risc16_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam logic [2:0] OP_LW = 3'b101;
    localparam logic [2:0] OP_SW = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/risc16_ram256.sv
// Data-memory storage: one synchronous write port, one asynchronous read port, no reset.
module risc16_ram256 #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/risc16_dmem_resp.sv
// RISC16 data-memory responder: valid/ready request, fixed wait states, held response,
// plus a boot-loader write port usable only while idle.
module risc16_dmem_resp
    import risc16_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              busy
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t       state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              accept;
    logic              resp_entry;
    logic              eff_we;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_wdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    assign req_ready = (state == IDLE) && !ld_en && !rst;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);

    // Select the operation completing on this edge and steer the single RAM write port.
    // With zero wait states the RESP-entry edge is the acceptance edge, so the live
    // request fields are used instead of the (not yet loaded) latched copies.
    always_comb begin
        eff_we     = lat_we;
        eff_addr   = lat_addr;
        eff_wdata  = lat_wdata;
        resp_entry = 1'b0;
        if (state == IDLE) begin
            eff_we     = req_we;
            eff_addr   = req_addr;
            eff_wdata  = req_wdata;
            resp_entry = accept && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            resp_entry = (cnt == 4'd0);
        end
        ram_we    = 1'b0;
        ram_waddr = eff_addr;
        ram_wdata = eff_wdata;
        if ((state == IDLE) && ld_en) begin
            ram_we    = 1'b1;
            ram_waddr = ld_addr;
            ram_wdata = ld_data;
        end else if (resp_entry && eff_we) begin
            ram_we = 1'b1;
        end
    end

    risc16_ram256 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (eff_addr),
        .rdata (ram_rdata)
    );

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= eff_we ? eff_wdata : ram_rdata;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= eff_we ? eff_wdata : ram_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc16_dmem_resp.sv
// Directed bench for risc16_dmem_resp: a 2-wait-state instance and a 0-wait-state
// instance share one stimulus stream; outputs are sampled on the falling clock edge.
module tb_risc16_dmem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready, ld_en;
    logic [7:0]  req_addr, ld_addr;
    logic [15:0] req_wdata, ld_data;

    logic        req_ready, rsp_valid, busy;
    logic [15:0] rsp_rdata;
    logic        req_ready0, rsp_valid0, busy0;
    logic [15:0] rsp_rdata0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    risc16_dmem_resp #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy)
    );

    risc16_dmem_resp #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ld_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one request; returns at the falling edge where the 2-wait DUT first shows
    // rsp_valid. Latencies count falling edges after the acceptance edge.
    task automatic do_req(input logic we, input logic [7:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd,
                          output int lat0, output logic [15:0] rd0);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        #1;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
        lat = -1; lat0 = -1; rd = '0; rd0 = '0;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (rsp_valid0 && lat0 < 0) begin lat0 = i; rd0 = rsp_rdata0; end
            if (rsp_valid && lat < 0) begin lat = i; rd = rsp_rdata; end
            if (i == 1) begin
                req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~d;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, lat0;
        logic [15:0] rd, rd0;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Boot-load then load, both wait settings
        ld_write(8'h10, 16'h1234);
        do_req(1'b0, 8'h10, 16'h0000, lat, rd, lat0, rd0);
        check("ld10_latency", 32'(lat), 32'd3);
        check("ld10_data", 32'(rd), 32'h1234);
        check("w0_latency", 32'(lat0), 32'd1);
        check("w0_data", 32'(rd0), 32'h1234);
        check("resp_no_overlap", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ld10_done_valid", 32'(rsp_valid), 32'd0);
        check("ld10_done_busy", 32'(busy), 32'd0);

        // Store at top address, load it back, and check 8'h00 is a separate word
        ld_write(8'h00, 16'h00AA);
        do_req(1'b1, 8'hFF, 16'hBEEF, lat, rd, lat0, rd0);
        check("st_ff_latency", 32'(lat), 32'd3);
        check("st_ff_echo", 32'(rd), 32'hBEEF);
        do_req(1'b0, 8'hFF, 16'h0000, lat, rd, lat0, rd0);
        check("ld_ff_data", 32'(rd), 32'hBEEF);
        do_req(1'b0, 8'h00, 16'h0000, lat, rd, lat0, rd0);
        check("ld_00_data", 32'(rd), 32'h00AA);

        // Stalled response; loader write while busy must be dropped
        ld_write(8'h30, 16'hA5A5);
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h30, 16'h0000, lat, rd, lat0, rd0);
        check("stall_data", 32'(rd), 32'hA5A5);
        ld_en = 1'b1; ld_addr = 8'h30; ld_data = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", 32'(rsp_rdata), 32'hA5A5);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end
        ld_en = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stall_release_valid", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 8'h30, 16'h0000, lat, rd, lat0, rd0);
        check("ld_ignored_when_busy", 32'(rd), 32'hA5A5);

        // Loader and request together: loader wins, request accepted next cycle
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 8'h40; ld_data = 16'h7777;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_wdata = '0;
        #1;
        check("collide_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        ld_en = 1'b0;
        check("collide_not_accepted", 32'(busy), 32'd0);
        do_req(1'b0, 8'h40, 16'h0000, lat, rd, lat0, rd0);
        check("collide_latency", 32'(lat), 32'd3);
        check("collide_data", 32'(rd), 32'h7777);

        // Reset during WAIT abandons a pending store
        ld_write(8'h20, 16'h0001);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'h5555;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_req(1'b0, 8'h20, 16'h0000, lat, rd, lat0, rd0);
        check("midrst_latency", 32'(lat), 32'd3);
        check("midrst_old_data", 32'(rd), 32'h0001);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc16_dmem_resp.md
RISC16_DMEM_RESP -- requirements
Module: risc16_dmem_resp

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, the number of wait states between request acceptance and response; legal range 0..15.
REQ-002 SHALL have parameter ADDR_W, default 8, the word-address width (256 words).
REQ-003 SHALL have parameter DATA_W, default 16, the data word width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: asynchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1, initiator request present.
REQ-007 SHALL have port req_ready, output, 1, responder accepts a request this cycle.
REQ-008 SHALL have port req_we, input, 1, 1 = store (SW), 0 = load (LW).
REQ-009 SHALL have port req_addr, input, ADDR_W, word address (low 8 bits of rb+sext(imm7)).
REQ-010 SHALL have port req_wdata, input, DATA_W, store data (regs[ra]).
REQ-011 SHALL have port rsp_valid, output, 1, response present.
REQ-012 SHALL have port rsp_ready, input, 1, initiator accepts the response.
REQ-013 SHALL have port rsp_rdata, output, DATA_W, load data, or store data echoed for stores.
REQ-014 SHALL have port ld_en, input, 1, boot-loader direct write strobe.
REQ-015 SHALL have port ld_addr, input, ADDR_W, boot-loader write address.
REQ-016 SHALL have port ld_data, input, DATA_W, boot-loader write data.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-019 SHALL drive req_ready = (state==IDLE) && !ld_en && !rst.
REQ-020 SHALL accept a request on an edge where req_valid && req_ready, latching req_we, req_addr and req_wdata; later input changes are ignored.
REQ-021 SHALL on acceptance go IDLE->WAIT and load the wait counter with WAIT_CYCLES-1 when WAIT_CYCLES>0; otherwise go IDLE->RESP directly.
REQ-022 SHALL in WAIT decrement the counter each cycle and go WAIT->RESP on the edge where the counter equals 0.
REQ-023 SHALL on the RESP-entry edge write the latched data into memory for stores, and register mem[addr] (loads) or the latched wdata (stores) into rsp_rdata.
REQ-024 SHALL make rsp_valid high exactly in RESP, i.e. WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-025 SHALL hold rsp_valid and rsp_rdata stable in RESP until rsp_ready; on the edge with rsp_valid && rsp_ready, go RESP->IDLE and clear rsp_valid.
REQ-026 SHALL not accept a new request in the same cycle as a response handshake (no back-to-back overlap); the minimum request period is WAIT_CYCLES+2 cycles.
REQ-027 SHALL write ld_data to mem[ld_addr] on any edge with ld_en high while in IDLE; ld_en outside IDLE SHALL be ignored (no write).
REQ-028 SHALL give ld_en priority over req_valid in IDLE in the same cycle (the request is not accepted).
REQ-029 SHALL wrap addresses modulo 2^ADDR_W; address 255 is valid and 0 follows it.
REQ-030 SHALL return the new value for a load issued after a completed store to the same address.

Reset
REQ-031 SHALL, while rst is high, force state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, busy 0, req_ready 0.
REQ-032 SHALL abandon an in-flight request on mid-operation reset; a pending store whose RESP-entry edge has not occurred SHALL NOT be written.
REQ-033 SHALL leave memory contents unchanged by reset.

Structure
REQ-034 SHALL take ADDR_W, DATA_W defaults and the FSM state encoding (IDLE=0, WAIT=1, RESP=2) from shared package risc16_pkg, alongside the LW='b101 and SW='b100 opcode constants.
REQ-035 SHALL place the storage in sub-module risc16_ram256 (one synchronous write port, one read port, no reset).

Verification
REQ-036 SHALL cover: WAIT_CYCLES=2, ld_en writes 16'h1234 at 8'h10, then load 8'h10 with rsp_ready=1 -> rsp_valid exactly 3 cycles after acceptance, rsp_rdata=16'h1234.
REQ-037 SHALL cover: store 16'hBEEF at 8'hFF then load 8'hFF -> store response echoes 16'hBEEF, load returns 16'hBEEF.
REQ-038 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 and busy 1 throughout.
REQ-039 SHALL cover: ld_en and req_valid both high in IDLE -> req_ready 0, load write occurs, request accepted next cycle.
REQ-040 SHALL cover: store 16'h5555 to 8'h20 (old 16'h0001), rst pulsed during WAIT -> rsp_valid 0, state IDLE, later load of 8'h20 returns 16'h0001.
REQ-041 SHALL cover: WAIT_CYCLES=0, load -> rsp_valid 1 cycle after acceptance.
